// File: rtl/vgafb_fifo_wconv.sv
// rtl/vgafb_fifo_wconv.sv - width-down-converting FIFO feeding the VGA pixel pipeline
module vgafb_fifo_wconv #(
    parameter int IN_W       = 64,
    parameter int OUT_W      = 16,
    parameter int DEPTH      = 4,
    parameter int LOW_THRESH = 8,
    parameter int MSB_FIRST  = 1,
    localparam int RATIO     = IN_W / OUT_W,
    localparam int CAP       = DEPTH * RATIO,
    localparam int LW        = $clog2(CAP + 1)
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             flush,
    input  logic             in_stb,
    input  logic [IN_W-1:0]  in_di,
    output logic             in_ack,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_do,
    input  logic             out_next,
    output logic [LW-1:0]    level,
    output logic             low_water,
    output logic             overflow,
    output logic             underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(RATIO);
    localparam int CW = PW + SW;

    localparam logic [LW-1:0] ACK_MAX = LW'(CAP - RATIO);
    localparam logic [LW-1:0] RATIO_L = LW'(RATIO);
    localparam logic [LW-1:0] ONE_L   = LW'(1);

    logic [IN_W-1:0] mem [DEPTH];
    logic [PW-1:0]   produce_ptr;
    logic [CW-1:0]   consume_ptr;
    logic            wr_en;
    logic            rd_en;
    logic [SW-1:0]   sub_sel;
    logic [IN_W-1:0] rd_word;

    // Status comes from level alone so neither neighbour sees a combinational path.
    assign in_ack    = (level <= ACK_MAX);
    assign out_valid = (level != '0);
    assign low_water = (int'(level) <= LOW_THRESH);

    assign wr_en = in_stb & in_ack & ~flush;
    assign rd_en = out_next & out_valid & ~flush;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            produce_ptr <= '0;
            consume_ptr <= '0;
            level       <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else if (flush) begin
            produce_ptr <= '0;
            consume_ptr <= '0;
            level       <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (wr_en) begin
                produce_ptr <= produce_ptr + 1'b1;
            end
            if (rd_en) begin
                consume_ptr <= consume_ptr + 1'b1;
            end
            level <= level + (wr_en ? RATIO_L : '0) - (rd_en ? ONE_L : '0);
            if (in_stb && !in_ack) begin
                overflow <= 1'b1;
            end
            if (out_next && !out_valid) begin
                underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[produce_ptr] <= in_di;
        end
    end

    // With MSB-first order, sub-word k sits at slot RATIO-1-k, i.e. the bitwise inverse.
    assign sub_sel = consume_ptr[SW-1:0] ^ {SW{MSB_FIRST != 0}};
    assign rd_word = mem[consume_ptr[CW-1:SW]];

    always_comb begin
        out_do = '0;
        if (out_valid) begin
            out_do = rd_word[sub_sel*OUT_W +: OUT_W];
        end
    end

endmodule

// File: tb/tb_vgafb_fifo_wconv.sv
// tb/tb_vgafb_fifo_wconv.sv - scoreboard bench for vgafb_fifo_wconv
module tb_vgafb_fifo_wconv;

    localparam int IN_W  = 64;
    localparam int OUT_W = 16;
    localparam int DEPTH = 4;
    localparam int LOWT  = 8;
    localparam int RATIO = IN_W / OUT_W;
    localparam int CAP   = DEPTH * RATIO;
    localparam int LW    = $clog2(CAP + 1);

    logic             sys_clk;
    logic             sys_rst_n;
    logic             flush;
    logic             in_stb;
    logic [IN_W-1:0]  in_di;
    logic             in_ack;
    logic             out_valid;
    logic [OUT_W-1:0] out_do;
    logic             out_next;
    logic [LW-1:0]    level;
    logic             low_water;
    logic             overflow;
    logic             underflow;

    int checks = 0;
    int errors = 0;

    logic [OUT_W-1:0] exp_q[$];
    logic             m_ovf;
    logic             m_udf;

    vgafb_fifo_wconv #(
        .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .LOW_THRESH(LOWT), .MSB_FIRST(1)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .flush(flush),
        .in_stb(in_stb), .in_di(in_di), .in_ack(in_ack),
        .out_valid(out_valid), .out_do(out_do), .out_next(out_next),
        .level(level), .low_water(low_water),
        .overflow(overflow), .underflow(underflow)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: a queue of narrow words plus sticky flags, advanced on each edge.
    always @(negedge sys_clk) begin
        int n;
        bit acc;
        bit rd;
        if (!sys_rst_n) begin
            exp_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            n = exp_q.size();
            chk("mon_level", 64'(level), 64'(n));
            chk("mon_in_ack", 64'(in_ack), 64'(n <= CAP - RATIO));
            chk("mon_out_valid", 64'(out_valid), 64'(n != 0));
            chk("mon_low_water", 64'(low_water), 64'(n <= LOWT));
            chk("mon_overflow", 64'(overflow), 64'(m_ovf));
            chk("mon_underflow", 64'(underflow), 64'(m_udf));
            chk("mon_out_do", 64'(out_do), (n != 0) ? 64'(exp_q[0]) : 64'd0);
            if (flush) begin
                exp_q.delete();
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end else begin
                acc = in_stb && (n <= CAP - RATIO);
                rd  = out_next && (n != 0);
                if (in_stb && !acc) m_ovf = 1'b1;
                if (out_next && !rd) m_udf = 1'b1;
                if (rd) void'(exp_q.pop_front());
                if (acc) begin
                    for (int i = 0; i < RATIO; i++) begin
                        exp_q.push_back(in_di[IN_W-1-i*OUT_W -: OUT_W]);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic write_word(input logic [IN_W-1:0] w);
        in_stb = 1'b1;
        in_di  = w;
        cyc();
        in_stb = 1'b0;
    endtask

    task automatic read_one();
        out_next = 1'b1;
        cyc();
        out_next = 1'b0;
    endtask

    initial begin
        int tx;
        int rx;
        logic [15:0] exp_words [4];
        exp_words[0] = 16'h1111;
        exp_words[1] = 16'h2222;
        exp_words[2] = 16'h3333;
        exp_words[3] = 16'h4444;

        sys_rst_n = 1'b0;
        flush     = 1'b0;
        in_stb    = 1'b0;
        in_di     = '0;
        out_next  = 1'b0;
        #3;
        chk("rst_in_ack", 64'(in_ack), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_do", 64'(out_do), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_low_water", 64'(low_water), 64'd1);
        #5;
        sys_rst_n = 1'b1;
        cyc();

        // Sub-word order
        write_word(64'h1111_2222_3333_4444);
        for (int i = 0; i < 4; i++) begin
            chk("order_do", 64'(out_do), 64'(exp_words[i]));
            read_one();
        end
        chk("order_valid", 64'(out_valid), 64'd0);
        chk("order_level", 64'(level), 64'd0);

        // Underflow
        read_one();
        chk("udf_flag", 64'(underflow), 64'd1);
        chk("udf_level", 64'(level), 64'd0);

        // Full and overflow
        for (int i = 0; i < DEPTH; i++) write_word({$urandom, $urandom});
        chk("full_level", 64'(level), 64'd16);
        chk("full_in_ack", 64'(in_ack), 64'd0);
        write_word(64'hDEAD_BEEF_CAFE_F00D);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_level", 64'(level), 64'd16);
        read_one();
        chk("partial_level", 64'(level), 64'd15);
        chk("partial_in_ack", 64'(in_ack), 64'd0);

        // Flush beats a concurrent write
        flush  = 1'b1;
        in_stb = 1'b1;
        in_di  = 64'h5555_6666_7777_8888;
        cyc();
        flush  = 1'b0;
        in_stb = 1'b0;
        chk("flush_level", 64'(level), 64'd0);
        chk("flush_udf", 64'(underflow), 64'd0);
        chk("flush_ovf", 64'(overflow), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_do", 64'(out_do), 64'd0);

        // Simultaneous write and read
        write_word(64'hA001_A002_A003_A004);
        write_word(64'hB001_B002_B003_B004);
        for (int i = 0; i < 3; i++) read_one();
        chk("sim_pre_level", 64'(level), 64'd5);
        chk("sim_pre_do", 64'(out_do), 64'hA004);
        in_stb   = 1'b1;
        in_di    = 64'hC001_C002_C003_C004;
        out_next = 1'b1;
        cyc();
        in_stb   = 1'b0;
        out_next = 1'b0;
        chk("sim_level", 64'(level), 64'd8);
        chk("sim_do", 64'(out_do), 64'hB001);
        flush = 1'b1;
        cyc();
        flush = 1'b0;

        // Long randomized stream across many pointer wraps
        tx = 0;
        rx = 0;
        for (int c = 0; c < 20000 && rx < 4000; c++) begin
            in_stb   = (tx < 1000) && in_ack && ($urandom_range(0, 3) != 0);
            in_di    = {16'(4*tx), 16'(4*tx+1), 16'(4*tx+2), 16'(4*tx+3)};
            out_next = out_valid && ($urandom_range(0, 2) != 0);
            if (in_stb) tx++;
            if (out_next) begin
                chk("stream_do", 64'(out_do), 64'(16'(rx)));
                rx++;
            end
            cyc();
        end
        in_stb   = 1'b0;
        out_next = 1'b0;
        chk("stream_count", 64'(rx), 64'd4000);
        chk("stream_ovf", 64'(overflow), 64'd0);
        chk("stream_udf", 64'(underflow), 64'd0);
        chk("stream_level", 64'(level), 64'd0);

        // Asynchronous reset mid-operation
        write_word(64'h0123_4567_89AB_CDEF);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("arst_level", 64'(level), 64'd0);
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ack", 64'(in_ack), 64'd1);
        cyc();
        sys_rst_n = 1'b1;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
